// File: rtl/synth_tone_voice.sv
// -----------------------------------------------------------------------------
// synth_tone_voice
//   Turns the one-hot key code from the PS/2 key decoder (A,S,D,F = bits 3..0)
//   into a square-wave tone (C4,D4,E4,F4). An envelope sets the tone's
//   amplitude. The block emits signed PCM samples with a one-cycle valid strobe
//   at the audio sample rate.
//
//   Build option: SYNTH_ENVELOPE_EN
//     defined   -> IDLE/ATTACK/SUSTAIN/RELEASE envelope with ENV_STEP ramps
//     undefined -> IDLE/SUSTAIN only; the level jumps between 0 and AMP_MAX
//                  on the sample tick.
//
// Ports
//   clock         in   1   system clock, all logic on posedge
//   resetn        in   1   asynchronous active-low reset
//   key_onehot    in   4   key code, asynchronous to clock
//   sample        out  16  signed two's-complement PCM sample
//   sample_valid  out  1   one-cycle pulse when sample updates
//   note_active   out  1   high while the envelope is not IDLE
//   note_idx      out  2   current pitch: 3=C, 2=D, 1=E, 0=F
// -----------------------------------------------------------------------------
module synth_tone_voice #(
    parameter int SAMPLE_DIV = 1042,
    parameter int HALF_C     = 95556,
    parameter int HALF_D     = 85131,
    parameter int HALF_E     = 75842,
    parameter int HALF_F     = 71586,
    parameter int AMP_MAX    = 8000,
    parameter int ENV_STEP   = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [3:0]         key_onehot,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               note_active,
    output logic [1:0]         note_idx
);

    localparam int HALF_MAX_CD = (HALF_C > HALF_D) ? HALF_C : HALF_D;
    localparam int HALF_MAX_EF = (HALF_E > HALF_F) ? HALF_E : HALF_F;
    localparam int HALF_MAX    = (HALF_MAX_CD > HALF_MAX_EF) ? HALF_MAX_CD : HALF_MAX_EF;
    localparam int PH_W        = (HALF_MAX > 2) ? $clog2(HALF_MAX) : 1;
    localparam int TICK_W      = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [15:0] LVL_MAX = 16'(AMP_MAX);

    // Elaboration-time guard: the level is negated into a 16-bit signed sample.
    if (AMP_MAX < 1 || AMP_MAX >= 32768 || ENV_STEP < 1) begin : g_bad_params
        $error("synth_tone_voice: AMP_MAX must be 1..32767 and ENV_STEP >= 1");
    end

`ifdef SYNTH_ENVELOPE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ATTACK, ST_SUSTAIN, ST_RELEASE} env_state_t;
    localparam logic [15:0] LVL_STEP = 16'(ENV_STEP);
`else
    typedef enum logic [0:0] {ST_IDLE, ST_SUSTAIN} env_state_t;
`endif

    logic [3:0]        r_key_s1, r_key_s2;
    logic              w_key_down;
    logic [1:0]        w_key_idx;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_last;
    logic              r_square;
    logic [1:0]        r_note_idx;
    env_state_t        r_state;
    logic [15:0]       r_level;
    logic [15:0]       w_level_nxt;
    logic signed [15:0] w_mag;
    logic signed [15:0] r_sample;
    logic              r_sample_valid;
    logic              r_note_active;

    // Two-flop synchronizer on the asynchronous key code.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
        end else begin
            r_key_s1 <= key_onehot;
            r_key_s2 <= r_key_s1;
        end
    end

    // Exactly one bit set is a key press; none or several reads as key up.
    assign w_key_down = $onehot(r_key_s2);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_key_idx = 2'd0;
        if (r_key_s2[3])      w_key_idx = 2'd3;
        else if (r_key_s2[2]) w_key_idx = 2'd2;
        else if (r_key_s2[1]) w_key_idx = 2'd1;
    end

    // Sample-rate tick: asserted during the last count of each period.
    assign w_tick = (r_tick_cnt == TICK_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Terminal phase count for the current pitch.
    always_comb begin
        w_phase_last = PH_W'(HALF_F - 1);
        case (r_note_idx)
            2'd3:    w_phase_last = PH_W'(HALF_C - 1);
            2'd2:    w_phase_last = PH_W'(HALF_D - 1);
            2'd1:    w_phase_last = PH_W'(HALF_E - 1);
            default: w_phase_last = PH_W'(HALF_F - 1);
        endcase
    end

    // Square-wave oscillator. A new key restarts the waveform from its high
    // half, so a retune never begins with a truncated half-period.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_note_idx <= 2'd0;
            r_phase    <= '0;
            r_square   <= 1'b1;
        end else if (w_key_down && (w_key_idx != r_note_idx)) begin
            r_note_idx <= w_key_idx;
            r_phase    <= '0;
            r_square   <= 1'b1;
        end else if (r_phase == w_phase_last) begin
            r_phase    <= '0;
            r_square   <= ~r_square;
        end else begin
            r_phase    <= r_phase + 1'b1;
        end
    end

`ifdef SYNTH_ENVELOPE_EN
    logic [16:0] w_level_sum;
    logic [15:0] w_level_up;
    logic [15:0] w_level_dn;

    // Saturating ramp steps; the 17-bit sum keeps the clamp correct near the top.
    assign w_level_sum = {1'b0, r_level} + {1'b0, LVL_STEP};
    assign w_level_up  = (w_level_sum >= {1'b0, LVL_MAX}) ? LVL_MAX : w_level_sum[15:0];
    assign w_level_dn  = (r_level <= LVL_STEP) ? 16'd0 : (r_level - LVL_STEP);

    // Next envelope level. A key press in RELEASE turns the ramp around
    // without a step that cycle.
    always_comb begin
        w_level_nxt = r_level;
        case (r_state)
            ST_ATTACK:  if (w_tick)                w_level_nxt = w_level_up;
            ST_RELEASE: if (w_tick && !w_key_down) w_level_nxt = w_level_dn;
            default:    w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_level       <= 16'd0;
            r_note_active <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_down) begin
                        r_state       <= ST_ATTACK;
                        r_note_active <= 1'b1;
                    end
                end
                ST_ATTACK: begin
                    // A release wins over reaching the peak; the step still lands.
                    if (!w_key_down) begin
                        r_state <= ST_RELEASE;
                    end else if (w_tick && (w_level_up == LVL_MAX)) begin
                        r_state <= ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    if (!w_key_down) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_key_down) begin
                        r_state <= ST_ATTACK;
                    end else if (w_tick && (w_level_dn == 16'd0)) begin
                        r_state       <= ST_IDLE;
                        r_note_active <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_note_active <= 1'b0;
                end
            endcase
        end
    end
`else
    // Gate mode: the level jumps between 0 and AMP_MAX on the sample tick.
    always_comb begin
        w_level_nxt = r_level;
        case (r_state)
            ST_IDLE:    if (w_tick && w_key_down)  w_level_nxt = LVL_MAX;
            ST_SUSTAIN: if (w_tick && !w_key_down) w_level_nxt = 16'd0;
            default:    w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_level       <= 16'd0;
            r_note_active <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && w_key_down) begin
                        r_state       <= ST_SUSTAIN;
                        r_note_active <= 1'b1;
                    end
                end
                ST_SUSTAIN: begin
                    if (w_tick && !w_key_down) begin
                        r_state       <= ST_IDLE;
                        r_note_active <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_note_active <= 1'b0;
                end
            endcase
        end
    end
`endif

    // The sample carries the level being committed on this tick, so the first
    // tick of a ramp already shows the new step.
    assign w_mag = signed'(w_level_nxt);

    // NOTE: output registers are reset so nothing undefined reaches the codec after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sample       <= 16'sd0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= w_tick;
            if (w_tick) begin
                r_sample <= r_square ? w_mag : -w_mag;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign note_active  = r_note_active;
    assign note_idx     = r_note_idx;

endmodule

// File: tb/tb_synth_tone_voice.sv
// -----------------------------------------------------------------------------
// tb_synth_tone_voice
//   Self-checking bench for synth_tone_voice with small parameters
//   (SAMPLE_DIV=4, HALF_C=10, HALF_D=9, HALF_E=8, HALF_F=7, AMP_MAX=100,
//   ENV_STEP=25). Each table row sets the key right after a sample strobe and
//   gives the sample, note_active and note_idx expected on the next strobe.
//   Expected values follow SYNTH_ENVELOPE_EN, so the bench matches either build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_synth_tone_voice;

    logic               clock;
    logic               resetn;
    logic [3:0]         key_onehot;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               note_active;
    logic [1:0]         note_idx;

    int n_checks = 0;
    int n_errors = 0;

    synth_tone_voice #(
        .SAMPLE_DIV (4),
        .HALF_C     (10),
        .HALF_D     (9),
        .HALF_E     (8),
        .HALF_F     (7),
        .AMP_MAX    (100),
        .ENV_STEP   (25)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_onehot   (key_onehot),
        .sample       (sample),
        .sample_valid (sample_valid),
        .note_active  (note_active),
        .note_idx     (note_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]         key;
        logic signed [15:0] smp;
        logic               act;
        logic [1:0]         idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Waits (bounded) for the next sample strobe, observed on a falling edge.
    task automatic next_tick(output int gap);
        gap = 0;
        do begin
            @(negedge clock);
            gap++;
        end while (sample_valid !== 1'b1 && gap < 20);
        if (sample_valid !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick_timeout: no sample_valid within %0d clocks (t=%0t)", gap, $time);
        end
    endtask

    task automatic add(input logic [3:0] k, input int s, input logic a, input logic [1:0] i);
        vec_t v;
        v.key = k;
        v.smp = 16'(s);
        v.act = a;
        v.idx = i;
        vecs.push_back(v);
    endtask

    task automatic check_tick(input string name, input int s, input logic a, input logic [1:0] i);
        int gap;
        next_tick(gap);
        check({name, "_sample"}, sample, s);
        check({name, "_active"}, note_active, a);
        check({name, "_idx"}, note_idx, i);
    endtask

    initial begin
        int gap;

        resetn     = 1'b0;
        key_onehot = 4'b0000;
        repeat (3) @(negedge clock);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_active", note_active, 0);
        check("rst_idx", note_idx, 0);
        resetn = 1'b1;

        // Idle: strobe every 4 clocks, silent output.
        next_tick(gap);
        for (int i = 0; i < 10; i++) begin
            next_tick(gap);
            check("idle_gap", gap, 4);
            check("idle_sample", sample, 0);
            check("idle_active", note_active, 0);
        end

`ifdef SYNTH_ENVELOPE_EN
        // C held: attack ramp, then sustain with the sign following the square.
        add(4'b1000,   25, 1, 3); add(4'b1000,   50, 1, 3); add(4'b1000,   75, 1, 3);
        add(4'b1000, -100, 1, 3); add(4'b1000, -100, 1, 3); add(4'b1000,  100, 1, 3);
        add(4'b1000,  100, 1, 3);
        // Retune to F in sustain: phase restarts high, 7-clock half-period.
        add(4'b0001,  100, 1, 0); add(4'b0001,  100, 1, 0); add(4'b0001, -100, 1, 0);
        add(4'b0001, -100, 1, 0); add(4'b0001,  100, 1, 0); add(4'b0001,  100, 1, 0);
        add(4'b0001, -100, 1, 0);
        // Two keys read as key up: release ramp to idle.
        add(4'b1100,   75, 1, 0); add(4'b1100,   50, 1, 0); add(4'b1100,  -25, 1, 0);
        add(4'b1100,    0, 0, 0); add(4'b1100,    0, 0, 0);
        // C again, then all keys up from sustain.
        add(4'b1000,   25, 1, 3); add(4'b1000,   50, 1, 3); add(4'b1000,   75, 1, 3);
        add(4'b1000, -100, 1, 3); add(4'b1000, -100, 1, 3);
        add(4'b0000,   75, 1, 3); add(4'b0000,   50, 1, 3); add(4'b0000,   25, 1, 3);
        add(4'b0000,    0, 0, 3); add(4'b0000,    0, 0, 3);
`else
        add(4'b1000,  100, 1, 3); add(4'b1000,  100, 1, 3); add(4'b1000,  100, 1, 3);
        add(4'b1000, -100, 1, 3); add(4'b1000, -100, 1, 3); add(4'b1000,  100, 1, 3);
        add(4'b1000,  100, 1, 3);
        add(4'b0001,  100, 1, 0); add(4'b0001,  100, 1, 0); add(4'b0001, -100, 1, 0);
        add(4'b0001, -100, 1, 0); add(4'b0001,  100, 1, 0); add(4'b0001,  100, 1, 0);
        add(4'b0001, -100, 1, 0);
        add(4'b1100,    0, 0, 0); add(4'b1100,    0, 0, 0);
        add(4'b1000,  100, 1, 3); add(4'b1000,  100, 1, 3);
        add(4'b0000,    0, 0, 3); add(4'b0000,    0, 0, 3);
`endif

        foreach (vecs[i]) begin
            key_onehot = vecs[i].key;
            next_tick(gap);
            check($sformatf("vec%0d_sample", i), sample, vecs[i].smp);
            check($sformatf("vec%0d_active", i), note_active, vecs[i].act);
            check($sformatf("vec%0d_idx", i), note_idx, vecs[i].idx);
        end

        // Reset mid-note: outputs clear immediately, no release tail.
        key_onehot = 4'b0100;
`ifdef SYNTH_ENVELOPE_EN
        check_tick("d_t1", 25, 1, 2);
        check_tick("d_t2", 50, 1, 2);
`else
        check_tick("d_t1", 100, 1, 2);
`endif
        resetn = 1'b0;
        #1;
        check("mid_rst_sample", sample, 0);
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_active", note_active, 0);
        check("mid_rst_idx", note_idx, 0);
        key_onehot = 4'b0000;
        @(negedge clock);
        resetn = 1'b1;
        check_tick("post_rst", 0, 0, 0);

`ifdef SYNTH_ENVELOPE_EN
        // Key up lands on the tick edge in ATTACK: step taken, then release.
        key_onehot = 4'b1000;
        check_tick("kt_t1", 25, 1, 3);
        check_tick("kt_t2", 50, 1, 3);
        @(negedge clock);
        key_onehot = 4'b0000;
        check_tick("kt_t3", 75, 1, 3);
        check_tick("kt_t4", -50, 1, 3);
        check_tick("kt_t5", -25, 1, 3);
        check_tick("kt_t6", 0, 0, 3);
`else
        // Key arrives too late for the first tick: 2-cycle sync latency.
        repeat (2) @(negedge clock);
        key_onehot = 4'b1000;
        check_tick("late_t1", 0, 0, 0);
        check_tick("late_t2", 100, 1, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
